// File: rtl/inv_shiftrows_serial_pkg.sv
// Shared AES byte-serial definitions for the InvShiftRows stage.
//   AES_BLOCK_BYTES : bytes per cipher-state block
//   byte_idx_t      : index of a byte within a block (i = 4*col + row)
//   bank_st_e       : lifecycle of one ping-pong bank
//   inv_sr_src()    : output index -> source index for InvShiftRows
//   fwd_sr_src()    : output index -> source index for forward ShiftRows
package inv_shiftrows_serial_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  typedef logic [3:0] byte_idx_t;

  typedef enum logic [1:0] {
    BANK_EMPTY    = 2'd0,
    BANK_FILLING  = 2'd1,
    BANK_FULL     = 2'd2,
    BANK_DRAINING = 2'd3
  } bank_st_e;

  // Output byte (r, c) takes input byte (r, (c - r) mod 4). The 2-bit column
  // subtraction wraps mod 4 on its own, giving the table
  // 0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3.
  function automatic byte_idx_t inv_sr_src(input byte_idx_t idx);
    logic [1:0] row;
    logic [1:0] col;
    row = idx[1:0];
    col = idx[3:2];
    return {col - row, row};
  endfunction

  // Forward ShiftRows: output byte (r, c) takes input byte (r, (c + r) mod 4).
  function automatic byte_idx_t fwd_sr_src(input byte_idx_t idx);
    logic [1:0] row;
    logic [1:0] col;
    row = idx[1:0];
    col = idx[3:2];
    return {col + row, row};
  endfunction

endpackage

// File: rtl/inv_shiftrows_serial_if.sv
// Byte-stream bundle for the InvShiftRows stage.
//   in_valid/in_ready/in_data          : upstream byte stream
//   out_valid/out_ready/out_data/out_last : downstream byte stream
// Handshake rule for both streams: a byte transfers on a rising clock edge
// where valid and ready are both high; a producer keeps valid (and data) up
// until that edge, and ready may change freely while valid is low.
// master = producer of in_* / consumer of out_*, slave = this stage.
interface inv_shiftrows_serial_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/inv_sr_index.sv
// Combinational InvShiftRows index map.
//   idx : output byte index (stream position)
//   src : input byte index that supplies it
module inv_sr_index
  import inv_shiftrows_serial_pkg::*;
(
  input  byte_idx_t idx,
  output byte_idx_t src
);
  assign src = inv_sr_src(idx);
endmodule

// File: rtl/inv_shiftrows_serial.sv
// Byte-serial AES InvShiftRows stage with a two-bank ping-pong buffer.
//   clk, rst      : clock, asynchronous active-high reset
//   s (slave)     : in_* byte stream in, out_* byte stream out (out_last on
//                   byte 15 of each block)
//   dbg_bank0_st  : lifecycle state of bank 0
//   dbg_bank1_st  : lifecycle state of bank 1
// One bank fills in stream order while the other drains in permuted order,
// so one byte per cycle flows in each direction. Outputs depend on
// registers only; there is no in->out combinational path.
module inv_shiftrows_serial
  import inv_shiftrows_serial_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  inv_shiftrows_serial_if.slave s,
  output bank_st_e              dbg_bank0_st,
  output bank_st_e              dbg_bank1_st
);

  bank_st_e     st_q [2];
  bank_st_e     st_d [2];
  logic [1:0]   full;
  logic         wr_bank;
  logic         rd_bank;
  byte_idx_t    wr_cnt;
  byte_idx_t    rd_cnt;
  logic [127:0] bank_q [2];
  byte_idx_t    src_idx;

  logic         in_ready_w;
  logic         out_valid_w;
  logic         wr_fire;
  logic         rd_fire;
  logic         wr_end;
  logic         rd_end;

  function automatic bank_st_e bank_next(input bank_st_e cur,
                                         input logic     wr_hit,
                                         input logic     wr_last,
                                         input logic     rd_hit,
                                         input logic     rd_last);
    bank_st_e nxt;
    nxt = cur;
    case (cur)
      BANK_EMPTY:    if (wr_hit)            nxt = BANK_FILLING;
      BANK_FILLING:  if (wr_hit && wr_last) nxt = BANK_FULL;
      BANK_FULL:     if (rd_hit)            nxt = BANK_DRAINING;
      BANK_DRAINING: if (rd_hit && rd_last) nxt = BANK_EMPTY;
      default:                              nxt = BANK_EMPTY;
    endcase
    return nxt;
  endfunction

  inv_sr_index u_rd_index (
    .idx (rd_cnt),
    .src (src_idx)
  );

  assign wr_fire = s.in_valid & in_ready_w;
  assign rd_fire = out_valid_w & s.out_ready;
  assign wr_end  = (wr_cnt == byte_idx_t'(AES_BLOCK_BYTES - 1));
  assign rd_end  = (rd_cnt == byte_idx_t'(AES_BLOCK_BYTES - 1));

  // State register: bank FSMs plus the write/read pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= BANK_EMPTY;
      st_q[1] <= BANK_EMPTY;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      wr_cnt  <= '0;
      rd_cnt  <= '0;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_end) wr_bank <= ~wr_bank;
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_end) rd_bank <= ~rd_bank;
      end
    end
  end

  // Bank storage carries no reset: contents only matter once a bank is full.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wr_bank][{wr_cnt, 3'b000} +: 8] <= s.in_data;
  end

  // Next state: write and read never hit the same bank in one cycle, so each
  // bank sees at most one event and both updates apply independently.
  always_comb begin
    st_d[0] = bank_next(st_q[0], wr_fire && !wr_bank, wr_end,
                        rd_fire && !rd_bank, rd_end);
    st_d[1] = bank_next(st_q[1], wr_fire &&  wr_bank, wr_end,
                        rd_fire &&  rd_bank, rd_end);
  end

  // Outputs. in_ready is held low during reset so nothing is captured then.
  always_comb begin
    full[0]     = (st_q[0] == BANK_FULL) || (st_q[0] == BANK_DRAINING);
    full[1]     = (st_q[1] == BANK_FULL) || (st_q[1] == BANK_DRAINING);
    in_ready_w  = ~full[wr_bank] & ~rst;
    out_valid_w = full[rd_bank];
  end

  assign s.in_ready  = in_ready_w;
  assign s.out_valid = out_valid_w;
  assign s.out_data  = out_valid_w ? bank_q[rd_bank][{src_idx, 3'b000} +: 8] : 8'h00;
  assign s.out_last  = out_valid_w & rd_end;

  assign dbg_bank0_st = st_q[0];
  assign dbg_bank1_st = st_q[1];

endmodule
